// File: rtl/seg_display_scan_if.sv
// Display-scan bus for seg_display_scan: the load strobe, the eight BCD/symbol
// digit codes (most to least significant), and the multiplexed display
// outputs with the busy flag. The controller side uses master; the scan
// engine uses slave.
interface seg_display_scan_if;
  logic       load;
  logic [3:0] dmilhao;
  logic [3:0] milhao;
  logic [3:0] cmilhar;
  logic [3:0] dmilhar;
  logic [3:0] milhar;
  logic [3:0] centesimal;
  logic [3:0] decimal;
  logic [3:0] unidade;
  logic [7:0] an;
  logic [6:0] seg;
  logic       busy;

  modport master (
    output load, dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade,
    input  an, seg, busy
  );

  modport slave (
    input  load, dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade,
    output an, seg, busy
  );
endinterface

// File: rtl/seg_display_scan.sv
// seg_display_scan: eight-digit multiplexed seven-segment driver.
// Digit codes are captured into a staging register on load and promoted to
// the displayed shadow register only at a frame boundary, so a frame never
// mixes old and new digits. Each digit is lit for REFRESH_DIV cycles.
// Optional feature: define LZ_BLANK_EN to blank leading zeros on digits 7..1.
module seg_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  seg_display_scan_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Segment decode {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hB:    s = 7'b0111111;
      4'hC:    s = 7'b0001001;
      4'hD:    s = 7'b1000111;
      4'hE:    s = 7'b0000111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic             pending_p0;
  logic [7:0][3:0]  staging_p0;
  logic [7:0][3:0]  shadow_p0;
  logic [7:0][3:0]  in_codes;
  logic             wrap;
  logic             frame_end;
  logic [6:0]       seg_next;
  logic [7:0]       an_p1;
  logic [6:0]       seg_p1;

  assign in_codes  = {bus.dmilhao, bus.milhao, bus.cmilhar, bus.dmilhar,
                      bus.milhar, bus.centesimal, bus.decimal, bus.unidade};
  assign wrap      = (cnt_p0 == CNT_MAX);
  assign frame_end = wrap && (idx_p0 == 3'd7);

  // Refresh timing, digit index, and the staging/shadow double buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      pending_p0 <= 1'b0;
      staging_p0 <= {8{CODE_BLANK}};
      shadow_p0  <= {8{CODE_BLANK}};
    end else begin
      if (wrap) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 3'd1;
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (frame_end && pending_p0) begin
        shadow_p0 <= staging_p0;
      end
      // A load on the boundary edge re-stages and keeps the request alive,
      // while the shadow takes the previously staged data.
      if (bus.load) begin
        staging_p0 <= in_codes;
        pending_p0 <= 1'b1;
      end else if (frame_end) begin
        pending_p0 <= 1'b0;
      end
    end
  end

`ifdef LZ_BLANK_EN
  logic [7:0] lz_mask;
  logic       lead;

  // Leading-zero mask: a zero digit is blanked while everything above it is
  // zero or blank; any other symbol ends the leading run. Digit 0 is exempt.
  always_comb begin
    lz_mask = '0;
    lead    = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (lead && (shadow_p0[k] == 4'h0)) begin
        lz_mask[k] = 1'b1;
      end
      lead = lead && ((shadow_p0[k] == 4'h0) || (shadow_p0[k] == 4'hA) ||
                      (shadow_p0[k] == 4'hF));
    end
  end

  // Segment pattern for the digit currently selected, with blanking applied.
  always_comb begin
    seg_next = seg_decode(shadow_p0[idx_p0]);
    if (lz_mask[idx_p0]) begin
      seg_next = SEG_OFF;
    end
  end
`else
  // Segment pattern for the digit currently selected.
  always_comb begin
    seg_next = seg_decode(shadow_p0[idx_p0]);
  end
`endif

  // Registered display outputs: exactly one anode low, following idx by a cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_p1  <= 8'hFF;
      seg_p1 <= SEG_OFF;
    end else begin
      an_p1  <= ~(8'h01 << idx_p0);
      seg_p1 <= seg_next;
    end
  end

  assign bus.an   = an_p1;
  assign bus.seg  = seg_p1;
  assign bus.busy = pending_p0;

endmodule
